// File: rtl/open_list_arbiter.sv
// open_list_arbiter: round-robin front end that shares one systolic min-priority
// open-list queue between NUM_REQ requesters (push / pop / replace), inserting
// SETTLE_CYCLES idle cycles after each issued op and returning popped heads
// tagged with the owning requester id.
// Optional build macro OPEN_LIST_ARB_STATS_EN adds saturating push/pop/stall counters.
module open_list_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 1,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [2*NUM_REQ-1:0]          i_req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_rsp_valid,
    output logic [ID_W-1:0]               o_rsp_id,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
`ifdef OPEN_LIST_ARB_STATS_EN
    output logic [31:0]                   o_push_cnt,
    output logic [31:0]                   o_pop_cnt,
    output logic [31:0]                   o_stall_cnt,
`endif
    output logic                          o_q_wrt,
    output logic                          o_q_read,
    output logic [DATA_WIDTH-1:0]         o_q_node_f,
    input  logic                          i_q_full,
    input  logic                          i_q_empty,
    input  logic [DATA_WIDTH-1:0]         i_q_node_f
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [CNT_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [1:0]            op_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    elig;
    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx;
    logic [1:0]            g_op;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  issue;

    // Unpack requester buses and decide who may be granted this cycle
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_arr[i]   = i_req_op[2*i +: 2];
            data_arr[i] = i_req_data[DATA_WIDTH*i +: DATA_WIDTH];
            // replace (11) is always eligible; the queue handles replace on full/empty
            elig[i] = i_req_valid[i] && (op_arr[i] != 2'b00)
                      && !((op_arr[i] == 2'b01) && i_q_full)
                      && !((op_arr[i] == 2'b10) && i_q_empty);
        end
    end

    // Round-robin search: first eligible requester at or after the rr pointer
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && elig[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign g_op   = op_arr[grant_idx];
    assign g_data = data_arr[grant_idx];
    assign issue  = (state_q == IDLE) && grant_found;

    // FSM state register plus rr pointer and settle counter
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // FSM next state: IDLE issues, GAP burns SETTLE_CYCLES cycles before the next grant
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        rr_d      = rr_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    gap_cnt_d = '0;
                    if (SETTLE_CYCLES > 0) state_d = GAP;
                    rr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    // FSM outputs: accept strobe and queue strobes only in an issuing IDLE cycle
    always_comb begin
        o_req_ready = '0;
        o_q_wrt     = 1'b0;
        o_q_read    = 1'b0;
        o_q_node_f  = '0;
        if (issue) begin
            o_req_ready[grant_idx] = 1'b1;
            o_q_wrt    = g_op[0];
            o_q_read   = g_op[1];
            o_q_node_f = g_data;
        end
    end

    // Response capture: head is sampled in the issue cycle of a pop/replace
    always_comb begin
        rsp_valid_d = issue && g_op[1];
        rsp_id_d    = rsp_valid_d ? grant_idx  : rsp_id_q;
        rsp_data_d  = rsp_valid_d ? i_q_node_f : rsp_data_q;
    end

    // Response register; a reset drops any in-flight response
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;

`ifdef OPEN_LIST_ARB_STATS_EN
    logic [31:0] push_cnt_q, push_cnt_d;
    logic [31:0] pop_cnt_q, pop_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Statistics next values: accepted pushes, accepted pop/replace, starved IDLE cycles
    always_comb begin
        push_cnt_d  = push_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (issue && (g_op == 2'b01)) push_cnt_d = sat_inc(push_cnt_q);
        if (issue && g_op[1])         pop_cnt_d  = sat_inc(pop_cnt_q);
        if ((state_q == IDLE) && (|i_req_valid) && !(|elig))
            stall_cnt_d = sat_inc(stall_cnt_q);
    end

    // Statistics registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            push_cnt_q  <= '0;
            pop_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            push_cnt_q  <= push_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_push_cnt  = push_cnt_q;
    assign o_pop_cnt   = pop_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_open_list_arbiter.sv
// Bench for open_list_arbiter: drives four requesters, models the attached
// min-priority queue, and checks grants and tagged responses via a scoreboard.
module tb_open_list_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int QCAP = 8;

    logic                 CLK = 1'b0;
    logic                 RSTn = 1'b0;
    logic [NR-1:0]        i_req_valid;
    logic [2*NR-1:0]      i_req_op;
    logic [DW*NR-1:0]     i_req_data;
    logic [NR-1:0]        o_req_ready;
    logic                 o_rsp_valid;
    logic [IW-1:0]        o_rsp_id;
    logic [DW-1:0]        o_rsp_data;
    logic                 o_q_wrt, o_q_read;
    logic [DW-1:0]        o_q_node_f;
    logic                 i_q_full, i_q_empty;
    logic [DW-1:0]        i_q_node_f;
`ifdef OPEN_LIST_ARB_STATS_EN
    logic [31:0]          o_push_cnt, o_pop_cnt, o_stall_cnt;
`endif

    open_list_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(1)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .i_req_valid(i_req_valid), .i_req_op(i_req_op), .i_req_data(i_req_data),
        .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
        .o_rsp_data(o_rsp_data),
`ifdef OPEN_LIST_ARB_STATS_EN
        .o_push_cnt(o_push_cnt), .o_pop_cnt(o_pop_cnt), .o_stall_cnt(o_stall_cnt),
`endif
        .o_q_wrt(o_q_wrt), .o_q_read(o_q_read), .o_q_node_f(o_q_node_f),
        .i_q_full(i_q_full), .i_q_empty(i_q_empty), .i_q_node_f(i_q_node_f)
    );

    always #5 CLK = ~CLK;

    // requester-side state
    logic [NR-1:0] req_valid;
    logic [1:0]    req_op   [NR];
    logic [DW-1:0] req_data [NR];

    always_comb begin
        i_req_valid = req_valid;
        i_req_op    = '0;
        i_req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            i_req_op[2*i +: 2]    = req_op[i];
            i_req_data[DW*i +: DW] = req_data[i];
        end
    end

    // queue model (sorted ascending, head at index 0)
    logic [DW-1:0] qm[$];
    logic          force_full;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    int glog[$];
    int gcyc[$];
    int cyc;
    int total;
    int bad;
    logic [DW-1:0] last_rsp_data;
    logic [1:0]    last_strobes;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive_q();
        i_q_empty  = (qm.size() == 0);
        i_q_full   = force_full || (qm.size() >= QCAP);
        i_q_node_f = (qm.size() == 0) ? '1 : qm[0];
    endtask

    task automatic q_insert(input logic [DW-1:0] v);
        int pos;
        pos = qm.size();
        for (int i = 0; i < qm.size(); i++)
            if (v < qm[i]) begin pos = i; break; end
        qm.insert(pos, v);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [DW-1:0] d);
        req_op[i]    = op;
        req_data[i]  = d;
        req_valid[i] = 1'b1;
    endtask

    // one clock: observe at negedge, apply accepted op to the queue model after posedge
    task automatic tick();
        int       g;
        logic     pend;
        logic [1:0] p_op;
        logic [DW-1:0] p_data;
        exp_t     e;
        g = -1;
        pend = 1'b0;
        p_op = 2'b00;
        p_data = '0;
        @(negedge CLK);
        if (o_rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(o_rsp_id), 64'hFF);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(o_rsp_id), 64'(e.id));
                chk("rsp_data", 64'(o_rsp_data), 64'(e.data));
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                last_rsp_data = o_rsp_data;
            end
        end
        if (o_req_ready != '0) begin
            chk("ready_onehot", 64'($onehot(o_req_ready)), 64'd1);
            for (int i = 0; i < NR; i++) if (o_req_ready[i]) g = i;
            chk("grant_valid", 64'(req_valid[g]), 64'd1);
            chk("q_wrt", 64'(o_q_wrt), 64'(req_op[g][0]));
            chk("q_read", 64'(o_q_read), 64'(req_op[g][1]));
            chk("q_node_f", 64'(o_q_node_f), 64'(req_data[g]));
            last_strobes = {o_q_wrt, o_q_read};
            if (req_op[g][1]) begin
                e.id = g; e.data = i_q_node_f; e.cyc = cyc + 1;
                sb.push_back(e);
            end
            glog.push_back(g);
            gcyc.push_back(cyc);
            pend = 1'b1; p_op = req_op[g]; p_data = req_data[g];
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (pend) begin
            req_valid[g] = 1'b0;
            if (p_op[1] && qm.size() != 0) void'(qm.pop_front());
            if (p_op[0]) q_insert(p_data);
            drive_q();
        end
    endtask

    task automatic wait_grants(input int n, input int budget, input string tag);
        int k;
        k = 0;
        glog.delete();
        gcyc.delete();
        while (glog.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (glog.size() < n) chk({tag, "_timeout"}, 64'(glog.size()), 64'(n));
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        force_full = 1'b0;
        req_valid = '0;
        last_rsp_data = '0;
        last_strobes = '0;
        for (int i = 0; i < NR; i++) begin req_op[i] = 2'b00; req_data[i] = '0; end
        drive_q();

        // reset, then 10 idle cycles with no valid
        repeat (3) @(posedge CLK);
        #1 RSTn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle_ctl", {55'd0, o_req_ready, o_rsp_valid, o_q_wrt, o_q_read, o_rsp_id}, 64'd0);
            chk("idle_data", {o_q_node_f, o_rsp_data}, 64'd0);
            @(posedge CLK);
            #1 cyc++;
        end

        // four simultaneous pushes: grants 0,1,2,3 two cycles apart
        set_req(0, 2'b01, 40); set_req(1, 2'b01, 30);
        set_req(2, 2'b01, 20); set_req(3, 2'b01, 10);
        wait_grants(4, 20, "push4");
        for (int i = 0; i < 4; i++) chk("push4_order", 64'(glog[i]), 64'(i));
        for (int i = 1; i < 4; i++) chk("push4_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd2);
        tick();
        chk("push4_no_rsp", 64'(sb.size()), 64'd0);

        // req2 pop returns the minimum, 10
        set_req(2, 2'b10, 0);
        wait_grants(1, 10, "pop2");
        chk("pop2_grant", 64'(glog[0]), 64'd2);
        chk("pop2_strobes", 64'(last_strobes), 64'b01);
        tick();
        chk("pop2_data", 64'(last_rsp_data), 64'd10);
        chk("pop2_drained", 64'(sb.size()), 64'd0);

        // drain remaining entries 20,30,40 through req0
        for (int n = 0; n < 3; n++) begin
            set_req(0, 2'b10, 0);
            wait_grants(1, 10, "drain");
            tick();
        end
        chk("drain_empty", 64'(i_q_empty), 64'd1);
        chk("drain_last", 64'(last_rsp_data), 64'd40);

        // empty queue: req1 pop skipped, req3 push 7 granted, then req1 gets 7
        set_req(1, 2'b10, 0);
        set_req(3, 2'b01, 7);
        wait_grants(2, 12, "skip");
        chk("skip_first", 64'(glog[0]), 64'd3);
        chk("skip_second", 64'(glog[1]), 64'd1);
        tick();
        chk("skip_data", 64'(last_rsp_data), 64'd7);

        // full queue: replace granted, push waits until full drops
        set_req(2, 2'b01, 15);
        wait_grants(1, 10, "pre_full");
        tick();
        force_full = 1'b1;
        drive_q();
        set_req(0, 2'b01, 99);
        set_req(1, 2'b11, 5);
        wait_grants(1, 10, "replace");
        chk("replace_grant", 64'(glog[0]), 64'd1);
        chk("replace_strobes", 64'(last_strobes), 64'b11);
        repeat (5) tick();
        chk("replace_data", 64'(last_rsp_data), 64'd15);
        chk("full_hold", 64'(glog.size()), 64'd1);
        chk("full_req0_waiting", 64'(req_valid[0]), 64'd1);
        force_full = 1'b0;
        drive_q();
        glog.delete();
        wait_grants(1, 10, "full_release");
        chk("full_release_grant", 64'(glog[0]), 64'd0);
        tick();

        // reset asserted in GAP with a response pending
        set_req(2, 2'b10, 0);
        wait_grants(1, 10, "rst_pop");
        RSTn = 1'b0;
        #1;
        chk("rst_rsp_dropped", 64'(o_rsp_valid), 64'd0);
        sb.delete();
        @(posedge CLK);
        #1 RSTn = 1'b1;
        cyc++;
        set_req(1, 2'b10, 0);
        set_req(3, 2'b10, 0);
        wait_grants(1, 10, "rst_rr");
        chk("rst_rr_grant", 64'(glog[0]), 64'd1);
        tick();
        chk("rst_rr_data", 64'(last_rsp_data), 64'd99);
        req_valid = '0;
        repeat (2) tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
